// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
//
// Purpose:
//   Shared definitions for the registered bus interconnect: the controller
//   state encoding, the default four-slave address map and a constant
//   ceiling-log2 helper used to size indices and counters.
//
// Contents:
//   STATE_IDLE / STATE_ACCESS / STATE_RESPOND  state encodings
//   bus_state_t                                controller state enum
//   DEFAULT_NUM_SLAVES, DEFAULT_ADDR_WIDTH     default map geometry
//   DEFAULT_SLAVE_BASE, DEFAULT_SLAVE_LIMIT    packed inclusive windows,
//                                              slave 0 in the LSB slice
//   clog2()                                    ceiling log2 for sizing
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_ACCESS  = 2'd1;
  localparam logic [1:0] STATE_RESPOND = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = STATE_IDLE,
    ACCESS  = STATE_ACCESS,
    RESPOND = STATE_RESPOND
  } bus_state_t;

  localparam int DEFAULT_NUM_SLAVES = 4;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  // Slave 0: 0x0000-0x0FFF, slave 1: 0x1000-0x1002,
  // slave 2: 0x1003-0x13BA, slave 3: 0x13BB-0x13BE.
  localparam logic [DEFAULT_NUM_SLAVES*DEFAULT_ADDR_WIDTH-1:0] DEFAULT_SLAVE_BASE =
    {32'h0000_13BB, 32'h0000_1003, 32'h0000_1000, 32'h0000_0000};
  localparam logic [DEFAULT_NUM_SLAVES*DEFAULT_ADDR_WIDTH-1:0] DEFAULT_SLAVE_LIMIT =
    {32'h0000_13BE, 32'h0000_13BA, 32'h0000_1002, 32'h0000_0FFF};

  // Number of bits needed to represent values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// ---------------------------------------------------------------------------
// bus_addr_decoder
//
// Purpose:
//   Purely combinational window decoder. Compares the request address with
//   every slave's inclusive [base, limit] window and reports whether any
//   window matched plus the index of the matching slave. When windows
//   overlap the lowest slave index takes priority.
//
// Ports:
//   address      in   ADDR_WIDTH             address to decode
//   base_table   in   NUM_SLAVES*ADDR_WIDTH  packed window starts (slave 0 LSB)
//   limit_table  in   NUM_SLAVES*ADDR_WIDTH  packed window ends   (slave 0 LSB)
//   hit          out  1                      some window contains the address
//   index        out  INDEX_WIDTH            lowest matching slave, 0 on miss
// ---------------------------------------------------------------------------
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 2
) (
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] base_table,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] limit_table,
  output logic                             hit,
  output logic [INDEX_WIDTH-1:0]           index
);

  // Scanning from the highest slave down lets a lower-indexed match
  // overwrite a higher one, which gives lowest-index priority.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((address >= base_table[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (address <= limit_table[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit   = 1'b1;
        index = INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// ---------------------------------------------------------------------------
// bus_interconnect
//
// Purpose:
//   Registered single-master, multi-slave interconnect between the core's
//   load/store unit and its memory/peripheral slaves. A request pulse is
//   decoded against a per-slave address window table; hits drive a held
//   strobe to the selected slave until it responds (wait states), misses and
//   illegal read+write requests complete immediately with an error and the
//   failing address is captured in error_address.
//
// Configuration:
//   BUS_TIMEOUT_EN  when defined, an access whose slave stays silent for
//                   TIMEOUT_CYCLES strobe cycles is aborted with an error.
//                   When undefined, an access waits indefinitely.
//
// Ports:
//   clk                in   1                      rising-edge clock
//   rst_n              in   1                      async active-low reset
//   master_read        in   1                      read request pulse
//   master_write       in   1                      write request pulse
//   master_address     in   ADDR_WIDTH             request address
//   master_write_data  in   DATA_WIDTH             request write data
//   master_read_data   out  DATA_WIDTH             last read result / 0 on error
//   master_response    out  1                      one-cycle completion pulse
//   master_error       out  1                      completion was a failure
//   busy               out  1                      transaction in flight
//   error_address      out  ADDR_WIDTH             address of last failed access
//   slave_read         out  NUM_SLAVES             one-hot read strobe
//   slave_write        out  NUM_SLAVES             one-hot write strobe
//   slave_address      out  ADDR_WIDTH             latched request address
//   slave_write_data   out  DATA_WIDTH             latched request write data
//   slave_read_data    in   NUM_SLAVES*DATA_WIDTH  packed per-slave read data
//   slave_response     in   NUM_SLAVES             per-slave completion
// ---------------------------------------------------------------------------
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES     = DEFAULT_NUM_SLAVES,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE  = DEFAULT_SLAVE_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LIMIT = DEFAULT_SLAVE_LIMIT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             master_read,
  input  logic                             master_write,
  input  logic [ADDR_WIDTH-1:0]            master_address,
  input  logic [DATA_WIDTH-1:0]            master_write_data,
  output logic [DATA_WIDTH-1:0]            master_read_data,
  output logic                             master_response,
  output logic                             master_error,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            error_address,
  output logic [NUM_SLAVES-1:0]            slave_read,
  output logic [NUM_SLAVES-1:0]            slave_write,
  output logic [ADDR_WIDTH-1:0]            slave_address,
  output logic [DATA_WIDTH-1:0]            slave_write_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
  input  logic [NUM_SLAVES-1:0]            slave_response
);

  localparam int INDEX_WIDTH = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1;
  localparam logic [NUM_SLAVES-1:0] ONE_HOT_BASE = NUM_SLAVES'(1);

  bus_state_t             state;
  logic                   op_read;
  logic [INDEX_WIDTH-1:0] sel_index;

  logic                   decode_hit;
  logic [INDEX_WIDTH-1:0] decode_index;
  logic [NUM_SLAVES-1:0]  decode_onehot;
  logic                   request;
  logic                   illegal_op;
  logic                   selected_response;
  logic [DATA_WIDTH-1:0]  selected_data;

`ifdef BUS_TIMEOUT_EN
  localparam int TIMER_WIDTH = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] timer;
  logic                   timer_expired;

  // The timer holds the number of completed ACCESS cycles, so the last
  // allowed cycle is the one where it reads TIMEOUT_CYCLES-1.
  assign timer_expired = (timer == TIMER_LAST);
`endif

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_decoder (
    .address    (master_address),
    .base_table (SLAVE_BASE),
    .limit_table(SLAVE_LIMIT),
    .hit        (decode_hit),
    .index      (decode_index)
  );

  assign request       = master_read | master_write;
  assign illegal_op    = master_read & master_write;
  assign decode_onehot = ONE_HOT_BASE << decode_index;

  // Route the selected slave's response and read data. Only the slave
  // latched at request time is observed; all other responses are ignored.
  always_comb begin
    selected_response = 1'b0;
    selected_data     = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_index == INDEX_WIDTH'(i)) begin
        selected_response = slave_response[i];
        selected_data     = slave_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Controller: every output is a register updated here. master_response
  // and master_error default low so they only pulse for the single cycle
  // the controller spends in RESPOND. busy covers ACCESS and RESPOND,
  // the states in which new request pulses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      op_read          <= 1'b0;
      sel_index        <= '0;
      master_read_data <= '0;
      master_response  <= 1'b0;
      master_error     <= 1'b0;
      busy             <= 1'b0;
      error_address    <= '0;
      slave_read       <= '0;
      slave_write      <= '0;
      slave_address    <= '0;
      slave_write_data <= '0;
`ifdef BUS_TIMEOUT_EN
      timer            <= '0;
`endif
    end else begin
      master_response <= 1'b0;
      master_error    <= 1'b0;

      case (state)
        IDLE: begin
          if (request) begin
            slave_address    <= master_address;
            slave_write_data <= master_write_data;
            op_read          <= master_read;
            sel_index        <= decode_index;
            busy             <= 1'b1;
            if (decode_hit && !illegal_op) begin
              state       <= ACCESS;
              slave_read  <= master_read  ? decode_onehot : '0;
              slave_write <= master_write ? decode_onehot : '0;
`ifdef BUS_TIMEOUT_EN
              timer       <= '0;
`endif
            end else begin
              // Unmapped or read+write together: fail without touching
              // any slave.
              state            <= RESPOND;
              master_response  <= 1'b1;
              master_error     <= 1'b1;
              master_read_data <= '0;
              error_address    <= master_address;
            end
          end
        end

        ACCESS: begin
          // A response in the expiry cycle still completes normally.
          if (selected_response) begin
            state           <= RESPOND;
            slave_read      <= '0;
            slave_write     <= '0;
            master_response <= 1'b1;
            if (op_read) begin
              master_read_data <= selected_data;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else if (timer_expired) begin
            state            <= RESPOND;
            slave_read       <= '0;
            slave_write      <= '0;
            master_response  <= 1'b1;
            master_error     <= 1'b1;
            master_read_data <= '0;
            error_address    <= slave_address;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end

        RESPOND: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          slave_read  <= '0;
          slave_write <= '0;
        end
      endcase
    end
  end

endmodule
